sata_rx_align: RTL and testbench
================================

Name: sata_rx_align

Overview:
- Receive-side counterpart of the per-port PHY interface transmit path.
- Takes raw 32-bit GTX receive words plus per-byte K flags, whose comma may sit in any byte lane.
- Finds the K28.5 comma lane and rotates each dword so the comma lands in lane 0.
- Qualifies lock on repeated ALIGNp and strips ALIGNp from the stream. Delivers dword-aligned data and K flag to the link layer on clk_75m.

Parameters:
- C_LOCK_CNT, 2: consecutive ALIGNp at the same comma lane required to enter LOCKED (1..15).
- C_LOSS_CNT, 4: consecutive K28.5 hits at a wrong lane that drop LOCKED back to HUNT (1..15).
- C_DROP_ALIGN, 1: 1 = ALIGNp removed from the output stream; 0 = passed through with phy2cs_valid=1.

Ports:
- clk_75m  in  1  PHY user clock; all logic on this clock.
- host_rst_n  in  1  asynchronous active-low reset.
- link_up  in  1  OOB complete; low forces HUNT (synchronous).
- rxdata_fis  in  32  raw GTX receive data; byte i = bits [8i+7:8i].
- rxcharisk  in  4  per-byte K flag for rxdata_fis.
- phy2cs_data  out  32  aligned dword; comma byte in [7:0].
- phy2cs_k  out  1  aligned dword is a primitive (lane-0 K flag).
- phy2cs_valid  out  1  phy2cs_data/phy2cs_k valid this cycle.
- aligned  out  1  state == LOCKED.
- align_det  out  1  one-cycle pulse per ALIGNp seen while LOCKED.
- comma_lane  out  2  current locked lane offset p.
- realign_cnt  out  8  number of LOCKED->HUNT transitions; saturates at 255.

Behaviour:
- Reset (host_rst_n=0): state=HUNT, p=0, all counters=0.
  - Outputs during reset: phy2cs_data=0, phy2cs_k=0, phy2cs_valid=0, aligned=0, align_det=0, comma_lane=0, realign_cnt=0.
- Comma hit: input byte i with rxcharisk[i]=1 and value 8'hBC.
  - More than one hit in one word counts as a wrong-lane hit when LOCKED.
  - Such a word is ignored in HUNT and CHECK.
- Stage d1 registers rxdata_fis/rxcharisk every cycle.
- Rotation with p:
  - word = {rxdata_fis[8p-1:0], d1_data[31:8p]}; p=0 gives d1_data.
  - K flags rotate identically.
- ALIGNp is rotated word 32'h7B4A4ABC with rotated K = 4'b0001.
- Outputs are registered. A dword whose first byte arrives in cycle n appears on the outputs in cycle n+2, for every p.
- States:
  - HUNT:
    - A single comma hit at lane i sets p=i and lock_cnt=1.
    - If C_LOCK_CNT=1, go to LOCKED; otherwise go to CHECK.
  - CHECK:
    - Each rotated ALIGNp at lane p increments lock_cnt.
    - lock_cnt reaching C_LOCK_CNT goes to LOCKED.
    - A comma hit at any other lane goes to HUNT and re-seeds from that hit in the same cycle.
    - Non-comma words hold state.
  - LOCKED:
    - A wrong-lane or multi-lane hit increments loss_cnt.
    - A correct-lane hit clears loss_cnt.
    - loss_cnt reaching C_LOSS_CNT goes to HUNT and increments realign_cnt.
- link_up=0 in any state: next state HUNT and counters cleared. realign_cnt increments only if leaving LOCKED. p is held.
- phy2cs_valid:
  - 1 only when LOCKED on the output cycle.
  - 0 for rotated ALIGNp when C_DROP_ALIGN=1.
  - When phy2cs_valid=0, phy2cs_data and phy2cs_k hold their last value.
- phy2cs_k = rotated K[0]. A K flag in rotated lanes 1..3 while LOCKED counts as a wrong-lane hit only if that byte is BC.
- The first dword after entering LOCKED is the word rotated in the transition cycle; no word is duplicated.
- align_det pulses even when the ALIGNp is dropped.
- Reset mid-stream: outputs return to their reset values within the same cycle (asynchronous).

Decomposition:
- Shared package sata_phy_pkg:
  - K28_5 = 8'hBC.
  - ALIGNP = 32'h7B4A4ABC, plus SYNCP and CONTP constants.
  - State encoding HUNT/CHECK/LOCKED as 2-bit localparams.
- One sub-module, sata_rx_rotate: combinational byte/K rotator (data, prev, p -> rotated data/K).
- The FSM and counters stay in the top module.

Test Plan:
- Comma in lane 0, ALIGNp twice then 32'h12345678 and SYNCp: aligned=1 after the 2nd ALIGNp; out 32'h12345678 k=0, then 32'hB5B5957C k=1; ALIGNp dropped; latency 2.
- Comma in lane 2 (raw words 32'h4ABC_xxxx / 32'h????7B4A pattern) repeated: comma_lane=2; data dword 32'hDEADBEEF split across raw words emerges intact at lane 0.
- LOCKED at p=0, then 4 consecutive ALIGNp shifted to lane 1: HUNT after the 4th, realign_cnt=1, then relock at p=1.
- LOCKED, 3 wrong-lane hits, 1 correct hit, 3 wrong-lane hits: stays LOCKED (loss_cnt cleared).
- link_up deasserted for 1 cycle while LOCKED: aligned=0 next cycle, phy2cs_valid=0 until 2 fresh ALIGNp.
- host_rst_n asserted mid-frame: all outputs 0 immediately; after release, HUNT with realign_cnt=0; run with C_DROP_ALIGN=0 to check ALIGNp passes with valid=1 and align_det=1.

Source files
------------

// File: rtl/sata_phy_pkg.sv
// Shared SATA PHY constants: primitive encodings, receive-align state encoding
// and a lane encoder for one-hot comma hit vectors.
package sata_phy_pkg;

  localparam logic [7:0]  K28_5  = 8'hBC;
  localparam logic [31:0] ALIGNP = 32'h7B4A4ABC;
  localparam logic [31:0] SYNCP  = 32'hB5B5957C;
  localparam logic [31:0] CONTP  = 32'h9999AA7C;

  localparam logic [1:0] ST_HUNT   = 2'd0;
  localparam logic [1:0] ST_CHECK  = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  typedef enum logic [1:0] {
    HUNT   = ST_HUNT,
    CHECK  = ST_CHECK,
    LOCKED = ST_LOCKED
  } rx_state_t;

  // Only meaningful for a one-hot input; anything else maps to lane 0.
  function automatic logic [1:0] hit_lane_of(input logic [3:0] hits);
    logic [1:0] lane;
    case (hits)
      4'b0010: lane = 2'd1;
      4'b0100: lane = 2'd2;
      4'b1000: lane = 2'd3;
      default: lane = 2'd0;
    endcase
    return lane;
  endfunction

endpackage

// File: rtl/sata_rx_rotate.sv
// Combinational byte/K rotator: builds a dword starting at byte p of the
// previous raw word, borrowing the missing high bytes from the current word.
module sata_rx_rotate (
  input  logic [31:0] data,
  input  logic [3:0]  k,
  input  logic [31:0] prev_data,
  input  logic [3:0]  prev_k,
  input  logic [1:0]  p,
  output logic [31:0] rot_data,
  output logic [3:0]  rot_k
);

  logic [63:0] cat_data;
  logic [7:0]  cat_k;

  assign cat_data = {data, prev_data};
  assign cat_k    = {k, prev_k};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [2:0] src;
      assign src                 = 3'(gi) + {1'b0, p};
      assign rot_data[8*gi +: 8] = cat_data[{src, 3'b000} +: 8];
      assign rot_k[gi]           = cat_k[src];
    end
  endgenerate

endmodule

// File: rtl/sata_rx_align.sv
// Receive comma alignment: locks onto the K28.5 lane of repeated ALIGNp,
// rotates every dword so the comma sits in byte 0 and strips ALIGNp.
module sata_rx_align
  import sata_phy_pkg::*;
#(
  parameter int C_LOCK_CNT   = 2,
  parameter int C_LOSS_CNT   = 4,
  parameter int C_DROP_ALIGN = 1
) (
  input  logic        clk_75m,
  input  logic        host_rst_n,
  input  logic        link_up,
  input  logic [31:0] rxdata_fis,
  input  logic [3:0]  rxcharisk,
  output logic [31:0] phy2cs_data,
  output logic        phy2cs_k,
  output logic        phy2cs_valid,
  output logic        aligned,
  output logic        align_det,
  output logic [1:0]  comma_lane,
  output logic [7:0]  realign_cnt
);

  localparam logic [3:0] LOCK_TGT = 4'(C_LOCK_CNT);
  localparam logic [3:0] LOSS_TGT = 4'(C_LOSS_CNT);

  logic [31:0] d1_data_reg;
  logic [3:0]  d1_k_reg;
  rx_state_t   state_reg, state_next;
  logic [1:0]  p_reg, p_next;
  logic [3:0]  lock_cnt_reg, lock_cnt_next, loss_cnt_reg, loss_cnt_next;
  logic [7:0]  realign_cnt_reg, realign_cnt_next;
  logic [31:0] data_reg;
  logic        k_reg, valid_reg, align_det_reg;

  logic [31:0] rot_data;
  logic [3:0]  rot_k, hit, lock_inc, loss_inc;
  logic [7:0]  realign_inc;
  logic [1:0]  hit_lane;
  logic        any_hit, single_hit, rot_is_align, seed, pass_word, det_word;

  sata_rx_rotate u_rotate (
    .data      (rxdata_fis),
    .k         (rxcharisk),
    .prev_data (d1_data_reg),
    .prev_k    (d1_k_reg),
    .p         (p_reg),
    .rot_data  (rot_data),
    .rot_k     (rot_k)
  );

  // Comma hits are taken on the delayed word, which is where a rotated dword starts.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_hit
      assign hit[gi] = d1_k_reg[gi] && (d1_data_reg[8*gi +: 8] == K28_5);
    end
  endgenerate

  assign any_hit      = |hit;
  assign single_hit   = $onehot(hit);
  assign hit_lane     = hit_lane_of(hit);
  assign rot_is_align = (rot_data == ALIGNP) && (rot_k == 4'b0001);
  assign lock_inc     = lock_cnt_reg + 4'd1;
  assign loss_inc     = loss_cnt_reg + 4'd1;
  assign realign_inc  = (realign_cnt_reg == 8'hFF) ? realign_cnt_reg : realign_cnt_reg + 8'd1;

  always_comb begin
    state_next       = state_reg;
    p_next           = p_reg;
    lock_cnt_next    = lock_cnt_reg;
    loss_cnt_next    = loss_cnt_reg;
    realign_cnt_next = realign_cnt_reg;
    seed             = 1'b0;
    if (!link_up) begin
      state_next    = HUNT;
      lock_cnt_next = '0;
      loss_cnt_next = '0;
      if (state_reg == LOCKED) realign_cnt_next = realign_inc;
    end else begin
      case (state_reg)
        HUNT: seed = single_hit;
        CHECK: begin
          if (single_hit && hit_lane != p_reg) begin
            seed = 1'b1;
          end else if (single_hit && rot_is_align) begin
            lock_cnt_next = lock_inc;
            if (lock_inc >= LOCK_TGT) state_next = LOCKED;
          end
        end
        LOCKED: begin
          if (single_hit && hit_lane == p_reg) begin
            loss_cnt_next = '0;
          end else if (any_hit) begin
            if (loss_inc >= LOSS_TGT) begin
              state_next       = HUNT;
              loss_cnt_next    = '0;
              lock_cnt_next    = '0;
              realign_cnt_next = realign_inc;
            end else begin
              loss_cnt_next = loss_inc;
            end
          end
        end
        default: state_next = HUNT;
      endcase
    end
    // A mis-laned hit in CHECK restarts the hunt from that hit immediately.
    if (seed) begin
      p_next        = hit_lane;
      lock_cnt_next = 4'd1;
      loss_cnt_next = '0;
      state_next    = (LOCK_TGT <= 4'd1) ? LOCKED : CHECK;
    end
  end

  assign det_word  = (state_next == LOCKED) && rot_is_align;
  assign pass_word = (state_next == LOCKED) && !((C_DROP_ALIGN != 0) && rot_is_align);

  always_ff @(posedge clk_75m or negedge host_rst_n) begin
    if (!host_rst_n) begin
      d1_data_reg     <= '0;
      d1_k_reg        <= '0;
      state_reg       <= HUNT;
      p_reg           <= '0;
      lock_cnt_reg    <= '0;
      loss_cnt_reg    <= '0;
      realign_cnt_reg <= '0;
      data_reg        <= '0;
      k_reg           <= 1'b0;
      valid_reg       <= 1'b0;
      align_det_reg   <= 1'b0;
    end else begin
      d1_data_reg     <= rxdata_fis;
      d1_k_reg        <= rxcharisk;
      state_reg       <= state_next;
      p_reg           <= p_next;
      lock_cnt_reg    <= lock_cnt_next;
      loss_cnt_reg    <= loss_cnt_next;
      realign_cnt_reg <= realign_cnt_next;
      valid_reg       <= pass_word;
      align_det_reg   <= det_word;
      if (pass_word) begin
        data_reg <= rot_data;
        k_reg    <= rot_k[0];
      end
    end
  end

  assign phy2cs_data  = data_reg;
  assign phy2cs_k     = k_reg;
  assign phy2cs_valid = valid_reg;
  assign aligned      = (state_reg == LOCKED);
  assign align_det    = align_det_reg;
  assign comma_lane   = p_reg;
  assign realign_cnt  = realign_cnt_reg;

endmodule

// File: tb/tb_sata_rx_align.sv
// Directed scoreboard bench for sata_rx_align: one instance drops ALIGNp,
// a second passes it through.
module tb_sata_rx_align;

  localparam logic [31:0] W_ALIGN = 32'h7B4A4ABC;
  localparam logic [31:0] W_SYNC  = 32'hB5B5957C;
  localparam logic [31:0] W_L1    = 32'h4A4ABC7B;  // ALIGNp starting in lane 1
  localparam logic [31:0] W_L2    = 32'h4ABC7B4A;  // ALIGNp starting in lane 2
  localparam logic [31:0] W_BAD   = 32'h00BC0000;  // lone comma in lane 2

  typedef struct packed {
    logic [31:0] data;
    logic        k;
    logic        det;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n, link_up, link_up2;
  logic [31:0] rxd, rxd2;
  logic [3:0]  rxk, rxk2;

  logic [31:0] data1, data2;
  logic        k1, k2, valid1, valid2, aligned1, aligned2, det1, det2;
  logic [1:0]  lane1, lane2;
  logic [7:0]  realign1, realign2;

  exp_t sb1[$];
  exp_t sb2[$];
  exp_t e1, e2;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  sata_rx_align dut (
    .clk_75m      (clk),
    .host_rst_n   (rst_n),
    .link_up      (link_up),
    .rxdata_fis   (rxd),
    .rxcharisk    (rxk),
    .phy2cs_data  (data1),
    .phy2cs_k     (k1),
    .phy2cs_valid (valid1),
    .aligned      (aligned1),
    .align_det    (det1),
    .comma_lane   (lane1),
    .realign_cnt  (realign1)
  );

  sata_rx_align #(.C_DROP_ALIGN(0)) dut_pass (
    .clk_75m      (clk),
    .host_rst_n   (rst_n),
    .link_up      (link_up2),
    .rxdata_fis   (rxd2),
    .rxcharisk    (rxk2),
    .phy2cs_data  (data2),
    .phy2cs_k     (k2),
    .phy2cs_valid (valid2),
    .aligned      (aligned2),
    .align_det    (det2),
    .comma_lane   (lane2),
    .realign_cnt  (realign2)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("[TB] ok %s = %0h", name, act);
    end
  endtask

  task automatic send(input logic [31:0] d, input logic [3:0] k);
    @(posedge clk);
    #1;
    rxd = d;
    rxk = k;
  endtask

  task automatic send2(input logic [31:0] d, input logic [3:0] k);
    @(posedge clk);
    #1;
    rxd2 = d;
    rxk2 = k;
  endtask

  task automatic push1(input logic [31:0] d, input logic k);
    sb1.push_back('{data: d, k: k, det: 1'b0});
  endtask

  task automatic push2(input logic [31:0] d, input logic k, input logic det);
    sb2.push_back('{data: d, k: k, det: det});
  endtask

  // Monitors: every valid output cycle consumes one expected dword.
  always @(negedge clk) begin
    if (rst_n && valid1) begin
      if (sb1.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL drop_out: got unexpected %h k=%b, expected no output", data1, k1);
      end else begin
        e1 = sb1.pop_front();
        chk("drop_out", {31'd0, k1, data1}, {31'd0, e1.k, e1.data});
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && valid2) begin
      if (sb2.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL pass_out: got unexpected %h k=%b, expected no output", data2, k2);
      end else begin
        e2 = sb2.pop_front();
        chk("pass_out", {30'd0, det2, k2, data2}, {30'd0, e2.det, e2.k, e2.data});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish, expected finish within 100us");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; link_up = 1'b0; link_up2 = 1'b0;
    rxd = '0; rxk = '0; rxd2 = '0; rxk2 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data",    64'(data1),    64'h0);
    chk("rst_k",       64'(k1),       64'h0);
    chk("rst_valid",   64'(valid1),   64'h0);
    chk("rst_aligned", 64'(aligned1), 64'h0);
    chk("rst_det",     64'(det1),     64'h0);
    chk("rst_lane",    64'(lane1),    64'h0);
    chk("rst_realign", 64'(realign1), 64'h0);
    @(negedge clk);
    rst_n = 1'b1; link_up = 1'b1;

    // Lane 0: two ALIGNp lock, data and SYNCp follow with latency 2.
    send(32'h0, 4'h0);
    send(W_ALIGN, 4'b0001);
    send(W_ALIGN, 4'b0001);
    push1(32'h12345678, 1'b0); send(32'h12345678, 4'b0000);
    push1(W_SYNC, 1'b1);       send(W_SYNC, 4'b0001);
    @(negedge clk);
    chk("lock_aligned", 64'(aligned1), 64'h1);
    chk("lock_det",     64'(det1),     64'h1);
    chk("lock_drop",    64'(valid1),   64'h0);
    push1(32'h0, 1'b0); send(32'h0, 4'h0);
    @(negedge clk);
    chk("lat2_data", 64'(data1), 64'h12345678);
    chk("lat2_det",  64'(det1),  64'h0);
    repeat (3) begin push1(32'h0, 1'b0); send(32'h0, 4'h0); end

    // Wrong-lane hits interrupted by a correct hit never reach the loss count.
    repeat (3) begin push1(W_BAD, 1'b0); send(W_BAD, 4'b0100); end
    send(W_ALIGN, 4'b0001);
    repeat (3) begin push1(W_BAD, 1'b0); send(W_BAD, 4'b0100); end
    send(W_ALIGN, 4'b0001);
    repeat (2) begin push1(32'h0, 1'b0); send(32'h0, 4'h0); end
    @(negedge clk);
    chk("loss_cleared", 64'(aligned1), 64'h1);

    // Stream shifts to lane 1: fourth wrong-lane ALIGNp drops lock, relock at p=1.
    repeat (3) begin push1(W_L1, 1'b0); send(W_L1, 4'b0010); end
    send(W_L1, 4'b0010);
    @(negedge clk);
    chk("loss3_locked", 64'(aligned1), 64'h1);
    send(W_L1, 4'b0010);
    send(W_L1, 4'b0010);
    @(negedge clk);
    chk("loss4_hunt",    64'(aligned1), 64'h0);
    chk("loss4_realign", 64'(realign1), 64'h1);
    send(W_L1, 4'b0010);
    push1(32'h12345678, 1'b0); send(32'h3456787B, 4'b0000);
    push1(32'h0, 1'b0);        send(32'h00000012, 4'b0000);
    repeat (3) begin push1(32'h0, 1'b0); send(32'h0, 4'h0); end
    @(negedge clk);
    chk("relock_aligned", 64'(aligned1), 64'h1);
    chk("relock_lane",    64'(lane1),    64'h1);

    // One-cycle link_up drop while locked.
    send(32'h0, 4'h0);
    @(posedge clk); #1; link_up = 1'b0;
    @(posedge clk); #1; link_up = 1'b1;
    @(negedge clk);
    chk("linkdn_aligned", 64'(aligned1), 64'h0);
    chk("linkdn_valid",   64'(valid1),   64'h0);
    chk("linkdn_realign", 64'(realign1), 64'h2);
    send(32'h0, 4'h0);
    send(W_L1, 4'b0010);
    send(W_L1, 4'b0010);
    send(W_L1, 4'b0010);
    @(negedge clk);
    chk("check_valid", 64'(valid1), 64'h0);
    push1(32'h12345678, 1'b0); send(32'h3456787B, 4'b0000);
    push1(32'h0, 1'b0);        send(32'h00000012, 4'b0000);
    repeat (2) begin push1(32'h0, 1'b0); send(32'h0, 4'h0); end
    @(negedge clk);
    chk("linkup_relock", 64'(aligned1), 64'h1);

    // Back to HUNT through link_up; p is held.
    send(32'h0, 4'h0);
    @(posedge clk); #1; link_up = 1'b0;
    repeat (2) @(posedge clk);
    #1; link_up = 1'b1;
    @(negedge clk);
    chk("hunt_lane_held", 64'(lane1),    64'h1);
    chk("hunt_realign",   64'(realign1), 64'h3);

    // Lane 2: DEADBEEF straddles two raw words and emerges whole.
    send(W_L2, 4'b0100);
    send(W_L2, 4'b0100);
    send(W_L2, 4'b0100);
    push1(32'hDEADBEEF, 1'b0); send(32'hBEEF7B4A, 4'b0000);
    send(32'h4ABCDEAD, 4'b0100);
    push1(32'h11110000, 1'b0); send(32'h00007B4A, 4'b0000);
    repeat (3) begin push1(32'h11111111, 1'b0); send(32'h11111111, 4'b0000); end
    @(negedge clk);
    chk("lane2_aligned", 64'(aligned1), 64'h1);
    chk("lane2_lane",    64'(lane1),    64'h2);

    // Asynchronous reset mid-stream.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    sb1.delete();
    #1;
    chk("arst_data",    64'(data1),    64'h0);
    chk("arst_valid",   64'(valid1),   64'h0);
    chk("arst_aligned", 64'(aligned1), 64'h0);
    chk("arst_lane",    64'(lane1),    64'h0);
    chk("arst_realign", 64'(realign1), 64'h0);
    rxd = '0; rxk = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_aligned", 64'(aligned1), 64'h0);
    chk("post_rst_realign", 64'(realign1), 64'h0);

    // Pass-through instance: ALIGNp delivered with valid=1 and align_det=1.
    link_up2 = 1'b1;
    send2(32'h0, 4'h0);
    send2(W_ALIGN, 4'b0001);
    push2(W_ALIGN, 1'b1, 1'b1);       send2(W_ALIGN, 4'b0001);
    push2(W_ALIGN, 1'b1, 1'b1);       send2(W_ALIGN, 4'b0001);
    push2(32'h12345678, 1'b0, 1'b0);  send2(32'h12345678, 4'b0000);
    @(negedge clk);
    chk("pass_valid",   64'(valid2),   64'h1);
    chk("pass_det",     64'(det2),     64'h1);
    chk("pass_aligned", 64'(aligned2), 64'h1);
    push2(32'h0, 1'b0, 1'b0);         send2(32'h0, 4'h0);
    send2(32'h0, 4'h0);
    @(posedge clk); #1; link_up2 = 1'b0;
    repeat (3) @(negedge clk);
    chk("pass_realign", 64'(realign2), 64'h1);

    chk("drop_sb_empty", 64'(sb1.size()), 64'h0);
    chk("pass_sb_empty", 64'(sb2.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
